// File: rtl/ram_dp_pkg.sv
// Shared types and helpers for the dual-port synchronous RAM.
// Holds the control FSM state type, the read-during-write policy encodings
// and the byte-enable width helper used to size the wr_be port.
package ram_dp_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Same-address read-during-write policy
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic int be_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/ram_dp_core.sv
// Storage array: byte-enable write port plus an unregistered read port.
// Ports: clk_i; write we_i/waddr_i/be_i/wdata_i (sampled on rising edge);
//        read raddr_i -> rdata_o combinationally, zero for addresses >= SIZE.
module ram_dp_core
    import ram_dp_pkg::*;
#(
    parameter int DW   = 8,
    parameter int AW   = 4,
    parameter int SIZE = 16
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [AW-1:0]           waddr_i,
    input  logic [be_width(DW)-1:0] be_i,
    input  logic [DW-1:0]           wdata_i,
    input  logic [AW-1:0]           raddr_i,
    output logic [DW-1:0]           rdata_o
);

    localparam int BW = be_width(DW);
    localparam logic [AW:0] SIZE_W = (AW+1)'(SIZE);

    // Contents are deliberately not reset; the owner zeroes them by sweeping.
    logic [DW-1:0] mem_q [SIZE];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int k = 0; k < BW; k++) begin
                if (be_i[k]) begin
                    mem_q[waddr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = ({1'b0, raddr_i} < SIZE_W) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/ram_dp_sync.sv
// Dual-port synchronous RAM with zero-fill sweep, read bypass and read pipeline.
// Ports: clk/rst_n; clr starts a sweep, busy flags it; wr_en/wr_addr/wr_be/data_in
//        write port; rd_en/rd_addr read port -> data_out/rd_valid RD_LATENCY edges later.
module ram_dp_sync
    import ram_dp_pkg::*;
#(
    parameter int data_width    = 8,
    parameter int address_width = 4,
    parameter int RAM_size      = 16,
    parameter int RD_LATENCY    = 1,
    parameter int RDW_MODE      = RDW_NEW
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    output logic                            busy,
    input  logic                            wr_en,
    input  logic [address_width-1:0]        wr_addr,
    input  logic [be_width(data_width)-1:0] wr_be,
    input  logic [data_width-1:0]           data_in,
    input  logic                            rd_en,
    input  logic [address_width-1:0]        rd_addr,
    output logic [data_width-1:0]           data_out,
    output logic                            rd_valid
);

    if ((data_width % 8) != 0 || data_width < 8) begin : g_bad_width
        $error("ram_dp_sync: data_width must be a non-zero multiple of 8");
    end
    if (RAM_size < 1 || RAM_size > (1 << address_width)) begin : g_bad_size
        $error("ram_dp_sync: RAM_size must be in 1..2**address_width");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_latency
        $error("ram_dp_sync: RD_LATENCY must be 1 or 2");
    end

    localparam int BW = be_width(data_width);
    localparam logic [address_width-1:0] LAST_ADDR = address_width'(RAM_size - 1);
    localparam logic [address_width:0]   SIZE_W    = (address_width+1)'(RAM_size);

    state_t                   state_q, state_d;
    logic [address_width-1:0] cnt_q, cnt_d;

    logic                     accept, flush, wr_go, rd_go;
    logic                     mem_we;
    logic [address_width-1:0] mem_waddr;
    logic [BW-1:0]            mem_be;
    logic [data_width-1:0]    mem_wdata, mem_rdata, rd_word;

    logic [RD_LATENCY-1:0]    pipe_vld_q;
    logic [data_width-1:0]    pipe_dat_q [RD_LATENCY];
    logic                     out_vld_q;
    logic [data_width-1:0]    out_dat_q;

    // ---------------- control FSM and sweep counter ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (clr) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (clr) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == ST_INIT);

    // A clr in READY takes the edge for itself: user accesses on that edge are
    // dropped, and anything in the read pipeline is discarded.
    assign accept = ~busy & ~clr;
    assign flush  = busy | clr;
    assign wr_go  = accept & wr_en & ({1'b0, wr_addr} < SIZE_W);
    assign rd_go  = accept & rd_en;

    // ---------------- storage ----------------
    assign mem_we    = busy | wr_go;
    assign mem_waddr = busy ? cnt_q : wr_addr;
    assign mem_be    = busy ? '1 : wr_be;
    assign mem_wdata = busy ? '0 : data_in;

    ram_dp_core #(
        .DW   (data_width),
        .AW   (address_width),
        .SIZE (RAM_size)
    ) u_core (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .be_i    (mem_be),
        .wdata_i (mem_wdata),
        .raddr_i (rd_addr),
        .rdata_o (mem_rdata)
    );

    // The core read is combinational and sees the pre-write word; new-data
    // mode patches the bytes being written this same edge.
    always_comb begin
        rd_word = mem_rdata;
        if (RDW_MODE == RDW_NEW && wr_go && wr_addr == rd_addr) begin
            for (int k = 0; k < BW; k++) begin
                if (wr_be[k]) begin
                    rd_word[k*8 +: 8] = data_in[k*8 +: 8];
                end
            end
        end
    end

    // ---------------- read pipeline ----------------
    // Stage 0 captures the read at its sampling edge; the output register
    // loads RD_LATENCY edges later and holds between valid reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe_dat_q[k] <= '0;
            end
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            pipe_vld_q[0] <= rd_go;
            if (rd_go) begin
                pipe_dat_q[0] <= rd_word;
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1] & ~flush;
                pipe_dat_q[k] <= pipe_dat_q[k-1];
            end
            out_vld_q <= pipe_vld_q[RD_LATENCY-1] & ~flush;
            if (pipe_vld_q[RD_LATENCY-1] & ~flush) begin
                out_dat_q <= pipe_dat_q[RD_LATENCY-1];
            end
        end
    end

    assign data_out = out_dat_q;
    assign rd_valid = out_vld_q;

endmodule

// File: tb/tb_ram_dp_sync.sv
// Bench for ram_dp_sync: three builds (8b/16w/lat1/new, 16b/12w/lat2/old,
// 8b/16w/lat2/new) share one stimulus stream and are checked every cycle
// against a word-array model that schedules read results by due cycle.
module tb_ram_dp_sync;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [3:0]  rd_addr = '0;
    logic [1:0]  wr_be = '0;
    logic [15:0] data_in = '0;

    logic        busy_a, busy_b, busy_c, vld_a, vld_b, vld_c;
    logic [7:0]  dout_a, dout_c;
    logic [15:0] dout_b;

    logic        busy_v [3];
    logic        vld_v  [3];
    logic [15:0] dout_v [3];
    assign busy_v[0] = busy_a;  assign busy_v[1] = busy_b;  assign busy_v[2] = busy_c;
    assign vld_v[0]  = vld_a;   assign vld_v[1]  = vld_b;   assign vld_v[2]  = vld_c;
    assign dout_v[0] = {8'h00, dout_a};
    assign dout_v[1] = dout_b;
    assign dout_v[2] = {8'h00, dout_c};

    always #5 clk = ~clk;

    ram_dp_sync #(.data_width(8), .address_width(4), .RAM_size(16), .RD_LATENCY(1), .RDW_MODE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be[0:0]), .data_in(data_in[7:0]),
        .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout_a), .rd_valid(vld_a));

    ram_dp_sync #(.data_width(16), .address_width(4), .RAM_size(12), .RD_LATENCY(2), .RDW_MODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .data_in(data_in),
        .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout_b), .rd_valid(vld_b));

    ram_dp_sync #(.data_width(8), .address_width(4), .RAM_size(16), .RD_LATENCY(2), .RDW_MODE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_c),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be[0:0]), .data_in(data_in[7:0]),
        .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout_c), .rd_valid(vld_c));

    // ---------------- scoring ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int d, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int sz(input int d);   return (d == 1) ? 12 : 16; endfunction
    function automatic int lat(input int d);  return (d == 0) ? 1 : 2;   endfunction
    function automatic bit newrdw(input int d); return d != 1;           endfunction
    function automatic int nbytes(input int d); return (d == 1) ? 2 : 1; endfunction

    function automatic bit [15:0] merge(input bit [15:0] old, input logic [15:0] din,
                                        input logic [1:0] be, input int nb);
        bit [15:0] r;
        r = old;
        for (int k = 0; k < nb; k++) if (be[k]) r[k*8 +: 8] = din[k*8 +: 8];
        return r;
    endfunction

    bit [15:0] mmem [3][16];
    int        init_left [3] = '{16, 12, 16};
    bit        sv [3][8];         // result due at cycle (slot index == due mod 8)
    bit [15:0] sd [3][8];
    int        cyc = 0;

    task automatic model_wipe(input int d);
        for (int a = 0; a < 16; a++) mmem[d][a] = '0;
        for (int s = 0; s < 8; s++) sv[d][s] = 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                model_wipe(d);
                init_left[d] = sz(d);
            end
        end else begin
            cyc = cyc + 1;
            for (int d = 0; d < 3; d++) begin
                bit [15:0] v;
                sv[d][(cyc - 1) & 7] = 1'b0;
                if (init_left[d] > 0) begin
                    init_left[d] = clr ? sz(d) : init_left[d] - 1;
                end else if (clr) begin
                    init_left[d] = sz(d);
                    model_wipe(d);
                end else begin
                    if (rd_en) begin
                        v = (int'(rd_addr) < sz(d)) ? mmem[d][rd_addr] : 16'h0000;
                        if (newrdw(d) && wr_en && wr_addr == rd_addr && int'(wr_addr) < sz(d))
                            v = merge(v, data_in, wr_be, nbytes(d));
                        sv[d][(cyc + lat(d)) & 7] = 1'b1;
                        sd[d][(cyc + lat(d)) & 7] = v;
                    end
                    if (wr_en && int'(wr_addr) < sz(d))
                        mmem[d][wr_addr] = merge(mmem[d][wr_addr], data_in, wr_be, nbytes(d));
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    bit [15:0] last [3];
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            bit ev;
            if (!rst_n) last[d] = '0;
            ev = rst_n && sv[d][cyc & 7];
            if (ev) last[d] = sd[d][cyc & 7];
            chk("busy", d, {15'd0, busy_v[d]}, {15'd0, init_left[d] > 0});
            chk("rd_valid", d, {15'd0, vld_v[d]}, {15'd0, ev});
            chk("data_out", d, dout_v[d], last[d]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_en = 1'b1; wr_addr = a; data_in = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd_stream(input int clr_at);
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1; rd_addr = 4'(i); clr = (i == clr_at);
            tick();
        end
        rd_en = 1'b0; clr = 1'b0;
    endtask

    // One isolated access with hand-computed expectations for each build.
    task automatic lit(input string name, input bit do_wr, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [3:0] ra, input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ec);
        int        cnt [3];
        logic [15:0] val [3];
        logic [15:0] ex [3];
        ex[0] = ea; ex[1] = eb; ex[2] = ec;
        for (int d = 0; d < 3; d++) begin cnt[d] = 0; val[d] = 'x; end
        wr_en = do_wr; wr_addr = wa; data_in = wd; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = ra;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        repeat (6) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) if (vld_v[d]) begin cnt[d]++; val[d] = dout_v[d]; end
        end
        for (int d = 0; d < 3; d++) begin
            chk({name, "_pulses"}, d, 16'(cnt[d]), 16'd1);
            chk(name, d, val[d], ex[d]);
        end
    endtask

    task automatic busy_count();
        int ca, cb;
        ca = 0; cb = 0;
        repeat (40) begin
            @(negedge clk);
            ca += int'(busy_a);
            cb += int'(busy_b);
        end
        chk("busy_len", 0, 16'(ca), 16'd16);
        chk("busy_len", 1, 16'(cb), 16'd12);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and initial sweep
        repeat (3) tick();
        rst_n = 1'b1;
        busy_count();
        tick();
        rd_stream(-1);
        idle(4);

        // Fill i^A5 and read back
        for (int i = 0; i < 16; i++) wr(4'(i), {8'hC3, 8'(i) ^ 8'hA5}, 2'b11);
        rd_stream(-1);
        idle(4);
        lit("fill_rd3", 1'b0, 4'd0, 16'h0, 4'd3, 16'h00A6, 16'hC3A6, 16'h00A6);

        // Byte enables, including an all-zero strobe
        wr(4'd3, 16'hBEEF, 2'b11);
        wr(4'd3, 16'h1234, 2'b01);
        wr(4'd3, 16'hFFFF, 2'b00);
        lit("byte_en", 1'b0, 4'd0, 16'h0, 4'd3, 16'h0034, 16'hBE34, 16'h0034);

        // Read-during-write on address 8, then write 8 / read 9
        wr(4'd8, 16'h5555, 2'b11);
        lit("rdw_same", 1'b1, 4'd8, 16'hAAAA, 4'd8, 16'h00AA, 16'h5555, 16'h00AA);
        lit("rdw_diff", 1'b1, 4'd8, 16'h1111, 4'd9, 16'h00AC, 16'hC3AC, 16'h00AC);

        // Out-of-range write/read (only the 12-word build drops it)
        wr(4'd13, 16'h7777, 2'b11);
        lit("oor_rd13", 1'b0, 4'd0, 16'h0, 4'd13, 16'h0077, 16'h0000, 16'h0077);
        rd_stream(-1);
        idle(4);

        // Randomized traffic with occasional clears
        for (int n = 0; n < 400; n++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            rd_en   = ($urandom_range(0, 3) != 0);
            wr_addr = 4'($urandom_range(0, 15));
            rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            wr_be   = 2'($urandom_range(0, 3));
            data_in = 16'($urandom);
            clr     = ($urandom_range(0, 59) == 0);
            tick();
        end
        idle(20);

        // Clear in the middle of a read stream, then everything reads zero
        rd_stream(5);
        idle(20);
        rd_stream(-1);
        idle(4);
        lit("after_clr", 1'b0, 4'd0, 16'h0, 4'd7, 16'h0000, 16'h0000, 16'h0000);

        // Reset in the middle of a sweep
        wr(4'd2, 16'h7777, 2'b11);
        lit("pre_rst", 1'b0, 4'd0, 16'h0, 4'd2, 16'h0077, 16'h7777, 16'h0077);
        clr = 1'b1; tick(); clr = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_dout", 0, dout_v[0], 16'h0000);
        chk("rst_dout", 1, dout_v[1], 16'h0000);
        chk("rst_dout", 2, dout_v[2], 16'h0000);
        chk("rst_busy", 0, {15'd0, busy_a}, 16'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        busy_count();
        tick();
        rd_stream(-1);
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_dp_sync.md
RAM_DP_SYNC -- requirements
Module: ram_dp_sync

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- data_width, 8, word width in bits; multiple of 8.
- address_width, 4, address bus width.
- RAM_size, 16, word count; 1 to 2**address_width.
- RD_LATENCY, 1, read latency in cycles; only 1 or 2 allowed.
- RDW_MODE, 1, same-address read-during-write policy: 1 = new data, 0 = old data.

REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.

REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- clr, in, 1, synchronous request to zero the whole array.
- busy, out, 1, clear sweep in progress.
- wr_en, in, 1, write strobe.
- wr_addr, in, address_width, write address.
- wr_be, in, data_width/8, byte enables; bit k selects byte k.
- data_in, in, data_width, write data.
- rd_en, in, 1, read strobe.
- rd_addr, in, address_width, read address.
- data_out, out, data_width, read data.
- rd_valid, out, 1, data_out carries the result of a read; one-cycle pulse.

Function
REQ-004 Control SHALL be a two-state FSM.
- INIT: sweep counter writes zero to addresses 0 to RAM_size-1, one per cycle; busy=1.
- READY: normal operation; busy=0.
REQ-005 INIT SHALL last exactly RAM_size cycles and then transition to READY.
REQ-006 clr=1 in READY SHALL enter INIT at the next edge with counter=0.
REQ-007 clr=1 in INIT SHALL restart the counter at 0.
REQ-008 While busy=1, wr_en and rd_en SHALL be ignored.
REQ-009 On entry to INIT, reads in flight SHALL be flushed: no rd_valid for them.
REQ-010 Write, in READY: at the edge where wr_en=1 and wr_addr<RAM_size, the block SHALL update only bytes with wr_be=1.
REQ-011 A write with wr_be=0 SHALL be a no-op.
REQ-012 Read, in READY: rd_en=1 sampled at edge N SHALL give data_out and rd_valid=1 after edge N+RD_LATENCY.
REQ-013 Back-to-back reads SHALL be accepted every cycle.
REQ-014 rd_addr>=RAM_size SHALL return data_out=0 with rd_valid=1.
REQ-015 wr_addr>=RAM_size SHALL drop the write.
REQ-016 data_out SHALL hold its last value while rd_valid=0.
REQ-017 Same-cycle write and read to the same address:
- RDW_MODE=1: read returns stored word with the enabled bytes replaced by data_in.
- RDW_MODE=0: read returns the pre-write word.
REQ-018 A read issued any cycle after a write SHALL return the written data, for both latencies.
REQ-019 Simultaneous write and read to different addresses SHALL both complete without interaction.

Reset
REQ-020 rst_n=0 SHALL immediately force busy=1, rd_valid=0, data_out=0, FSM=INIT, counter=0, and clear the read pipeline.
REQ-021 Array contents SHALL NOT be reset asynchronously; they SHALL be zeroed by the INIT sweep after rst_n rises.
REQ-022 Reset asserted mid-sweep or mid-read SHALL abandon that operation; the sweep restarts from 0 after release.

Structure
REQ-023 Package ram_dp_pkg SHALL hold the FSM state type, the RDW_MODE encodings, and a byte-enable-width function.
REQ-024 Storage SHALL be a sub-module ram_dp_core.
- Contents: array, byte-enable write port, unregistered read port.
- ram_dp_sync adds the FSM, sweep counter, bypass mux, and latency pipeline.
REQ-025 Illegal parameters (data_width not a multiple of 8, RAM_size>2**address_width, RD_LATENCY outside 1 to 2) SHALL stop elaboration with an error.

Verification
REQ-026 Reset and init: release rst_n -> busy=1 for exactly 16 cycles; then reading addresses 0 to 15 returns 0x00 with rd_valid one per cycle.
REQ-027 Fill and readback: write data i^0xA5 to address i for i=0 to 15, then read 0 to 15 back-to-back -> matching data at latency 1, and at latency 2 with a second build.
REQ-028 Byte enables: data_width=16, write 0xBEEF to address 3, then write 0x1234 with wr_be=2'b01 -> read of address 3 returns 0xBE34.
REQ-029 Read-during-write to address 8: stored 0x55, write 0xAA -> RDW_MODE=1 returns 0xAA; RDW_MODE=0 returns 0x55. A concurrent write to address 8 and read of address 9 returns the address-9 contents.
REQ-030 Mid-operation reset and clear:
- Pulse clr during a read stream -> no rd_valid for flushed reads; busy=1 for 16 cycles; all words then read 0.
- rst_n low mid-sweep -> data_out=0 immediately.
REQ-031 Out-of-range: RAM_size=12, write to address 13 then read 13 -> rd_valid=1 with data_out=0; addresses 0 to 11 unchanged.
